// File: rtl/npu_act_interp_pkg.sv
// Shared types and constant helpers for the NPU activation unit.
package npu_act_pkg;

    typedef enum logic [1:0] {
        ACT_PASS    = 2'd0,
        ACT_RELU    = 2'd1,
        ACT_TANH    = 2'd2,
        ACT_SIGMOID = 2'd3
    } act_mode_t;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic longint act_one(input int if_bits);
        return 64'sd1 <<< if_bits;
    endfunction

    // First magnitude beyond the LUT range: 2^(IF+XMAX_LOG2).
    function automatic longint act_xmax(input int if_bits, input int xmax_log2);
        return 64'sd1 <<< (if_bits + xmax_log2);
    endfunction

    // Number of magnitude bits below the LUT index, used for interpolation.
    function automatic int act_fb(input int if_bits, input int xmax_log2, input int aw);
        return if_bits + xmax_log2 - aw;
    endfunction

endpackage

// File: rtl/npu_act_interp_if.sv
// Stream and LUT-programming bundle of the activation unit.
interface npu_act_interp_if
    import npu_act_pkg::*;
#(
    parameter int DW    = 32,
    parameter int LANES = 4,
    parameter int AW    = 9
);
    logic                  in_valid;
    logic                  in_ready;
    act_mode_t             in_mode;
    logic [LANES*DW-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*DW-1:0]   out_data;
    logic                  lut_wr_en;
    logic [AW-1:0]         lut_wr_addr;
    logic [2*DW-1:0]       lut_wr_data;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        output lut_wr_en, lut_wr_addr, lut_wr_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        input  lut_wr_en, lut_wr_addr, lut_wr_data,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/npu_act_lane.sv
// One lane of the activation pipeline: magnitude/sign split, LUT lookup,
// linear interpolation and mode select, plus the lane's private LUT copy.
module npu_act_lane
    import npu_act_pkg::*;
#(
    parameter int DW        = 32,
    parameter int IF        = 19,
    parameter int SAMPLES   = 512,
    parameter int AW        = $clog2(SAMPLES),
    parameter int XMAX_LOG2 = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  act_mode_t       mode,
    input  logic [DW-1:0]   x,
    input  logic            lut_wr_en,
    input  logic [AW-1:0]   lut_wr_addr,
    input  logic [2*DW-1:0] lut_wr_data,
    output logic [DW-1:0]   y
);
    localparam int FB = act_fb(IF, XMAX_LOG2, AW);
    localparam int XB = IF + XMAX_LOG2;
    localparam logic [DW-1:0] ONE_V    = DW'(act_one(IF));
    localparam logic [DW-1:0] XMAX_V   = DW'(act_xmax(IF, XMAX_LOG2));
    localparam logic [DW-1:0] MAXPOS_V = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINNEG_V = {1'b1, {(DW-1){1'b0}}};

    if (FB < 1) begin : g_fb_check
        $error("npu_act_lane: IF + XMAX_LOG2 - AW must be at least 1");
    end

    // S1 inputs
    logic [DW-1:0]   xe_s;
    logic [DW-1:0]   a_s;
    // S1 registers
    logic [DW-1:0]   x1_r, a1_r;
    act_mode_t       mode1_r;
    logic            sign1_r;
    // S2 registers
    logic [DW-1:0]   x2_r;
    act_mode_t       mode2_r;
    logic            sign2_r, sat2_r;
    logic [AW-1:0]   idx2_r;
    logic [FB-1:0]   frac2_r;
    // S3 registers (LUT word lives in rd_r)
    logic [2*DW-1:0] rd_r;
    logic [DW-1:0]   x3_r;
    act_mode_t       mode3_r;
    logic            sign3_r, sat3_r;
    logic [FB-1:0]   frac3_r;
    logic [DW-1:0]   y3_s, dy3_s;
    // S4 registers
    logic [2*DW-1:0] p_s, dy_ext_s, frac_ext_s;
    logic [2*DW-1:0] p4_r;
    logic [DW-1:0]   x4_r, y4_r;
    act_mode_t       mode4_r;
    logic            sign4_r, sat4_r;
    // S5
    logic [DW-1:0]   mag_s, t_s, sum_s, res_s;
    logic [DW-1:0]   y_r;
    logic            p_unused_s;

    logic [2*DW-1:0] lut_mem [SAMPLES];

    // Select the function argument (halved for sigmoid) and take its magnitude.
    always_comb begin
        if (mode == ACT_SIGMOID) begin
            xe_s = $signed(x) >>> 1;
        end else begin
            xe_s = x;
        end
        if (xe_s == MINNEG_V) begin
            a_s = MAXPOS_V;
        end else if (xe_s[DW-1]) begin
            a_s = -xe_s;
        end else begin
            a_s = xe_s;
        end
    end

    // LUT storage: broadcast write; the read port moves with the pipe and
    // sees the old word when it collides with a write.
    always_ff @(posedge clk) begin
        if (lut_wr_en) begin
            lut_mem[lut_wr_addr] <= lut_wr_data;
        end
        if (advance) begin
            rd_r <= lut_mem[idx2_r];
        end
    end

    assign y3_s  = rd_r[2*DW-1:DW];
    assign dy3_s = rd_r[DW-1:0];

    // Slope times fraction, signed by unsigned, kept at full double width.
    always_comb begin
        dy_ext_s   = {{DW{dy3_s[DW-1]}}, dy3_s};
        frac_ext_s = {{(2*DW-FB){1'b0}}, frac3_r};
        p_s        = dy_ext_s * frac_ext_s;
    end

    // Datapath stage registers S1..S4; they only matter while their valid is set.
    always_ff @(posedge clk) begin
        if (advance) begin
            x1_r    <= x;
            mode1_r <= mode;
            sign1_r <= xe_s[DW-1];
            a1_r    <= a_s;

            x2_r    <= x1_r;
            mode2_r <= mode1_r;
            sign2_r <= sign1_r;
            sat2_r  <= (a1_r >= XMAX_V);
            idx2_r  <= a1_r[XB-1:FB];
            frac2_r <= a1_r[FB-1:0];

            x3_r    <= x2_r;
            mode3_r <= mode2_r;
            sign3_r <= sign2_r;
            sat3_r  <= sat2_r;
            frac3_r <= frac2_r;

            x4_r    <= x3_r;
            mode4_r <= mode3_r;
            sign4_r <= sign3_r;
            sat4_r  <= sat3_r;
            y4_r    <= y3_s;
            p4_r    <= p_s;
        end
    end

    // Interpolate, saturate, restore sign and pick the result for the mode.
    always_comb begin
        if (sat4_r) begin
            mag_s = ONE_V;
        end else begin
            mag_s = y4_r + p4_r[FB +: DW];
        end
        if (sign4_r) begin
            t_s = -mag_s;
        end else begin
            t_s = mag_s;
        end
        sum_s = ONE_V + t_s;
        case (mode4_r)
            ACT_TANH:    res_s = t_s;
            ACT_SIGMOID: res_s = {sum_s[DW-1], sum_s[DW-1:1]};
            ACT_RELU: begin
                if (x4_r[DW-1]) begin
                    res_s = {DW{1'b0}};
                end else begin
                    res_s = x4_r;
                end
            end
            ACT_PASS:    res_s = x4_r;
            default:     res_s = x4_r;
        endcase
    end

    // Discarded product bits (integer overflow part and sub-LSB fraction).
    assign p_unused_s = ^{p4_r[2*DW-1:FB+DW], p4_r[FB-1:0], sum_s[0]};

    // S5 output register, cleared by reset and held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r <= {DW{1'b0}};
        end else if (advance) begin
            y_r <= res_s;
        end
    end

    assign y = y_r;

endmodule

// File: rtl/npu_act_interp.sv
// Multi-lane activation unit: 5-stage stall-together pipeline with
// valid/ready handshake, LUT writes taking priority over input accepts.
module npu_act_interp
    import npu_act_pkg::*;
#(
    parameter int DW        = 32,
    parameter int IF        = 19,
    parameter int LANES     = 4,
    parameter int SAMPLES   = 512,
    parameter int AW        = $clog2(SAMPLES),
    parameter int XMAX_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    npu_act_interp_if.slave  bus
);
    logic [4:0]          valid_r;
    logic                advance_s;
    logic                accept_s;
    logic [LANES*DW-1:0] out_data_s;

    assign advance_s     = !valid_r[4] || bus.out_ready;
    assign bus.in_ready  = advance_s && !bus.lut_wr_en && !rst;
    assign accept_s      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid_r[4];
    assign bus.out_data  = out_data_s;

    // Stage-valid shift register; bit 4 is the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 5'b0_0000;
        end else if (advance_s) begin
            valid_r <= {valid_r[3:0], accept_s};
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        npu_act_lane #(
            .DW        (DW),
            .IF        (IF),
            .SAMPLES   (SAMPLES),
            .AW        (AW),
            .XMAX_LOG2 (XMAX_LOG2)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .advance     (advance_s),
            .mode        (bus.in_mode),
            .x           (bus.in_data[k*DW +: DW]),
            .lut_wr_en   (bus.lut_wr_en),
            .lut_wr_addr (bus.lut_wr_addr),
            .lut_wr_data (bus.lut_wr_data),
            .y           (out_data_s[k*DW +: DW])
        );
    end

endmodule

// File: doc/npu_act_interp.md
Name: npu_act_interp

Overview:
- Multi-lane, pipelined activation unit for the NPU vector datapath: tanh, sigmoid, ReLU and pass-through on signed fixed-point data.
- Nonlinear functions use a runtime-loadable LUT with linear interpolation between entries.
- Sits after the MVU reduction, before the vector register file writeback.
- Uses valid/ready flow control with backpressure.

Parameters:
- DW, 32, data width, signed two's complement
- IF, 19, fractional bits of in/out data; ONE = 2^IF
- LANES, 4, parallel lanes per beat
- SAMPLES, 512, LUT entries per lane
- AW, $clog2(SAMPLES), LUT address width
- XMAX_LOG2, 2, LUT covers |x| in [0, 2^XMAX_LOG2); FB = IF+XMAX_LOG2-AW interpolation bits, must be >= 1 (default 12)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_mode  in  2  0 PASS, 1 RELU, 2 TANH, 3 SIGMOID; per beat
- in_data  in  LANES*DW  lane k at [k*DW +: DW]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*DW  results, same lane packing
- lut_wr_en  in  1  LUT write, broadcast to all lanes
- lut_wr_addr  in  AW  entry index
- lut_wr_data  in  2*DW  {y_i[2DW-1:DW], dy_i[DW-1:0]}; dy_i = y_{i+1}-y_i, signed

Behaviour:
- Reset: out_valid=0, out_data=0, all stage valids=0, in_ready=0 during rst. LUT contents are not reset and are retained across rst.
- Stall: advance = !out_valid || out_ready.
  - in_ready = advance && !lut_wr_en.
  - All stages move together on advance, otherwise hold.
  - No bubbles are inserted. Throughput is 1 beat/cycle when unstalled.
- Latency: 5 advancing cycles from accept to out_valid.
- Beats exit in order and none are dropped or duplicated.
- S1: xe = x for TANH; xe = x>>>1 (arithmetic) for SIGMOID. Register sign = xe[DW-1], a = |xe|.
  - The most negative value maps to a = 2^(DW-1)-1.
- S2:
  - sat = (a >= 2^(IF+XMAX_LOG2)).
  - idx = a[IF+XMAX_LOG2-1:FB].
  - frac = a[FB-1:0], unsigned.
  - Present idx to the LUT.
- S3: LUT read registered, giving y_i and dy_i. 1-cycle synchronous read.
- S4: p = dy_i * frac, signed x unsigned, full 2*DW width, registered.
- S5: t = y_i + (p >>> FB), truncated to DW; if sat then t = ONE; if sign then t = -t. Output by mode:
  - TANH: t
  - SIGMOID: (ONE + t) >>> 1
  - RELU: x<0 ? 0 : x (original x carried through the pipe)
  - PASS: x
- LUT write ordering:
  - A read and write to the same address in the same cycle return old data (read-before-write).
  - Writes never stall in-flight beats.
  - Software drains the pipe before reprogramming if consistency is needed.
- Simultaneous lut_wr_en and in_valid: the write wins and the input is not accepted that cycle.
- out_data holds stable while out_valid && !out_ready.
- Reset mid-stream discards all in-flight beats; out_valid=0 the cycle after rst is sampled.

Decomposition:
- Package npu_act_pkg:
  - act_mode_t enum (ACT_PASS, ACT_RELU, ACT_TANH, ACT_SIGMOID)
  - ONE/XMAX constant functions of IF, XMAX_LOG2
  - FB derivation plus an elaboration-time assertion that FB >= 1
- Sub-module npu_act_lane: one lane's S1–S5 datapath plus its inferred simple dual-port LUT (M20K). Takes the shared advance and write signals as inputs.
- The top holds stage-valid pipeline, handshake and LANES-way generate.

Test Plan:
- Identity LUT (y_i = i<<FB, dy_i = 1<<FB), TANH:
  - x = 0x0003_1234 -> 0x0003_1234 (interpolation exact)
  - x = -0x0003_1234 -> 0xFFFC_EDCC
- Saturation, TANH: x = 2097152 -> 524288; x = -2621440 -> 0xFFF8_0000; x = 0x8000_0000 -> 0xFFF8_0000.
- Identity LUT, SIGMOID: x = 524288 (1.0) -> 393216 (0.75); x = -524288 -> 131072 (0.25).
- Mixed modes, back-to-back beats:
  - RELU x = -3 -> 0
  - PASS x = -3 -> 0xFFFF_FFFD
  - RELU x = 7 -> 7
  - Outputs arrive in order, exactly 5 cycles after accept.
- Backpressure: continuous in_valid, out_ready low 10 cycles.
  - Accepts stop once the pipe is full (5 beats).
  - Output holds stable.
  - 20 sequential beats emerge unchanged and in order.
- Reset and LUT write:
  - rst with 3 beats in flight -> out_valid 0 next cycle and no stale beat afterwards; LUT contents intact.
  - lut_wr_en with in_valid -> in_ready=0.
  - Same-address read/write returns old entry.
